// File: rtl/iter_muldiv_unit.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit: shift-add multiply and restoring divide,
// one bit per clock. Define FAST_ZERO_EN for a two-cycle early-out on zero operands or divisor.
module iter_muldiv_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              Write,
    output logic [ADDR_W-1:0] D_address,
    output logic [WIDTH-1:0]  D_data
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [WIDTH-1:0]    r_opa;
    logic [WIDTH-1:0]    r_opb;
    logic [ADDR_W-1:0]   r_rd;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_prod;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic                r_busy;
    logic                r_write;
    logic [ADDR_W-1:0]   r_d_addr;
    logic [WIDTH-1:0]    r_d_data;
`ifdef FAST_ZERO_EN
    logic                r_fast;
    logic                w_fast_hit;
    logic [WIDTH-1:0]    w_fast_result;
`endif

    logic [WIDTH:0]      w_mul_sum;
    logic [2*WIDTH-1:0]  w_prod_nxt;
    logic [WIDTH:0]      w_rem_shift;
    logic [WIDTH-1:0]    w_rem_sub;
    logic                w_q_bit;
    logic [WIDTH-1:0]    w_rem_nxt;
    logic [WIDTH-1:0]    w_quo_nxt;
    logic [WIDTH-1:0]    w_result;
    logic                w_finish;
    logic [WIDTH-1:0]    w_final;

    // Multiply: add multiplicand into the upper half on multiplier LSB, then shift right.
    always_comb begin
        w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opa} : '0);
        w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
    end

    // Divide: r_quo starts as the dividend and is shifted out MSB-first while quotient
    // bits enter at the LSB; a zero divisor naturally yields all-ones and the dividend.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_q_bit     = (w_rem_shift >= {1'b0, r_opb});
        w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_opb;
        w_rem_nxt   = w_q_bit ? w_rem_sub : w_rem_shift[WIDTH-1:0];
        w_quo_nxt   = {r_quo[WIDTH-2:0], w_q_bit};
    end

    always_comb begin
        w_result = '0;
        unique case (r_op)
            OP_MUL:   w_result = w_prod_nxt[WIDTH-1:0];
            OP_MULHU: w_result = w_prod_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  w_result = w_quo_nxt;
            OP_REMU:  w_result = w_rem_nxt;
            default:  w_result = '0;
        endcase
    end

`ifdef FAST_ZERO_EN
    always_comb begin
        w_fast_hit    = op[1] ? (rs2_data == '0) : ((rs1_data == '0) || (rs2_data == '0));
        w_fast_result = '0;
        unique case (r_op)
            OP_MUL, OP_MULHU: w_fast_result = '0;
            OP_DIVU:          w_fast_result = '1;
            OP_REMU:          w_fast_result = r_opa;
            default:          w_fast_result = '0;
        endcase
    end
`endif

    always_comb begin
        w_finish = (r_cnt == LAST_CNT);
        w_final  = w_result;
`ifdef FAST_ZERO_EN
        if (r_fast) begin
            w_finish = 1'b1;
            w_final  = w_fast_result;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_op     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_busy   <= 1'b0;
            r_write  <= 1'b0;
            r_d_addr <= '0;
            r_d_data <= '0;
`ifdef FAST_ZERO_EN
            r_fast   <= 1'b0;
`endif
        end else begin
            r_write <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_op    <= op;
                        r_opa   <= rs1_data;
                        r_opb   <= rs2_data;
                        r_rd    <= rd_addr;
                        r_cnt   <= '0;
                        r_prod  <= {{WIDTH{1'b0}}, rs2_data};
                        r_rem   <= '0;
                        r_quo   <= rs1_data;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
`ifdef FAST_ZERO_EN
                        r_fast  <= w_fast_hit;
`endif
                    end
                end
                StRun: begin
                    if (r_op[1]) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                    end else begin
                        r_prod <= w_prod_nxt;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_finish) begin
                        r_state  <= StDone;
                        // Register x0 is never written, but the result is still presented.
                        r_write  <= (r_rd != '0);
                        r_d_addr <= r_rd;
                        r_d_data <= w_final;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign Write     = r_write;
    assign D_address = r_d_addr;
    assign D_data    = r_d_data;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: directed vector table, control corner cases,
// async reset abort and randomized ops against an arithmetic reference model.
module tb_iter_muldiv_unit;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  rs2 = '0;
    logic [AW-1:0] rd = '0;
    logic          busy;
    logic          wr;
    logic [AW-1:0] daddr;
    logic [W-1:0]  ddata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_muldiv_unit #(
        .WIDTH  (W),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1),
        .rs2_data  (rs2),
        .rd_addr   (rd),
        .busy      (busy),
        .Write     (wr),
        .D_address (daddr),
        .D_data    (ddata)
    );

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] rd;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
`ifdef FAST_ZERO_EN
        if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
        return 33;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [AW-1:0] r,
                          input logic [W-1:0] exp);
        int            lat;
        int            nw;
        int            wc;
        bit            busy_ok;
        logic [W-1:0]  data_at;
        logic [AW-1:0] addr_at;
        lat     = latency(o, a, b);
        nw      = 0;
        wc      = 0;
        busy_ok = 1'b1;
        data_at = 'x;
        addr_at = 'x;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        rd    = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble operands to confirm they were latched.
        rs1   = W'($urandom);
        rs2   = W'($urandom);
        rd    = AW'($urandom);
        op    = 2'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (wr) begin
                nw++;
                if (wc == 0) wc = k;
            end
            if (busy !== (k <= lat)) busy_ok = 1'b0;
            if (k == lat) begin
                data_at = ddata;
                addr_at = daddr;
            end
        end
        check({name, " data"}, 64'(data_at), 64'(exp));
        check({name, " addr"}, 64'(addr_at), 64'(r));
        check({name, " write count"}, 64'(nw), (r != 0) ? 64'd1 : 64'd0);
        if (r != 0) check({name, " write cycle"}, 64'(wc), 64'(lat));
        check({name, " busy window"}, 64'(busy_ok), 64'd1);
    endtask

    initial begin
        int            nw;
        int            wc;
        logic [W-1:0]  data_at;
        logic [AW-1:0] addr_at;
        logic [1:0]    ro;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [AW-1:0] rr;

        vecs[0] = '{"mul_7x6",      2'd0, 32'd7,          32'd6,          5'd3,  32'd42};
        vecs[1] = '{"mulhu_ffff",   2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE};
        vecs[2] = '{"mul_ffff",     2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0001};
        vecs[3] = '{"divu_100_7",   2'd2, 32'd100,        32'd7,          5'd8,  32'd14};
        vecs[4] = '{"remu_100_7",   2'd3, 32'd100,        32'd7,          5'd9,  32'd2};
        vecs[5] = '{"divu_by0",     2'd2, 32'h1234_5678,  32'd0,          5'd10, 32'hFFFF_FFFF};
        vecs[6] = '{"remu_by0",     2'd3, 32'd5,          32'd0,          5'd11, 32'd5};
        vecs[7] = '{"mul_zero",     2'd0, 32'd0,          32'd12345,      5'd12, 32'd0};
        vecs[8] = '{"mulhu_zero",   2'd1, 32'hDEAD_BEEF,  32'd0,          5'd13, 32'd0};
        vecs[9] = '{"mul_rd0",      2'd0, 32'd3,          32'd4,          5'd0,  32'd12};

        #2 rst = 1'b0;
        #1;
        check("reset busy",  64'(busy),  64'd0);
        check("reset write", 64'(wr),    64'd0);
        check("reset addr",  64'(daddr), 64'd0);
        check("reset data",  64'(ddata), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                                 vecs[i].exp);

        // start re-pulsed with different operands during RUN must be ignored.
        nw = 0;
        wc = 0;
        data_at = '0;
        addr_at = '0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        rs1   = 32'd7;
        rs2   = 32'd6;
        rd    = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1;
                op    = 2'd2;
                rs1   = 32'd1000;
                rs2   = 32'd3;
                rd    = 5'd9;
            end
            if (k == 10) start = 1'b0;
            if (wr) begin
                nw++;
                wc      = k;
                data_at = ddata;
                addr_at = daddr;
            end
        end
        check("repulse write count", 64'(nw),      64'd1);
        check("repulse write cycle", 64'(wc),      64'd33);
        check("repulse data",        64'(data_at), 64'd42);
        check("repulse addr",        64'(addr_at), 64'd3);

        // Async reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        rs1   = 32'h1234;
        rs2   = 32'h5678;
        rd    = 5'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort busy",  64'(busy),  64'd0);
        check("abort write", 64'(wr),    64'd0);
        check("abort data",  64'(ddata), 64'd0);
        check("abort addr",  64'(daddr), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nw = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wr || busy) nw++;
        end
        check("abort no write after release", 64'(nw), 64'd0);
        run_op("mul_3x3_after_reset", 2'd0, 32'd3, 32'd3, 5'd7, 32'd9);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = '0;
                1:       ra = W'($urandom_range(1, 20));
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 20));
                default: rb = W'($urandom);
            endcase
            rr = AW'($urandom_range(0, 31));
            run_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, rr, model(ro, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
